time_display: RTL

Drives the eight DE2 seven-segment displays from the BCD time/date bus produced by the time-flow counter chain. It takes coherent snapshots of that bus, which changes on derived clocks, into the `CLOCK_50` domain. It shows one of two 8-digit pages, TIME or DATE, selected by button or automatic rotation. During time adjustment it forces the page that holds the digit being edited and blinks that digit.

---
 rtl/time_display_if.sv | 46 ++++
 rtl/time_display.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/time_display_if.sv
`default_nettype none
// ============================================================================
// Module      : time_display_if
// Description : Groups the BCD time/date bus, the adjust/select/page controls
//               and the eight seven-segment outputs of time_display.
//               slave  : display side (bus and controls in, HEX out)
//               master : source side (bus and controls out, HEX in)
//               Fields : millisecond[7:0] second[6:0] minute[6:0] hour[5:0]
//                        day[5:0] month[4:0] year_l[7:0] year_h[7:0] (BCD)
//                        adjust, select[3:0], page_btn, HEX0..HEX7[6:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface time_display_if;
  logic       adjust;
  logic [3:0] select;
  logic       page_btn;
  logic [7:0] millisecond;
  logic [6:0] second;
  logic [6:0] minute;
  logic [5:0] hour;
  logic [5:0] day;
  logic [4:0] month;
  logic [7:0] year_l;
  logic [7:0] year_h;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [6:0] HEX4;
  logic [6:0] HEX5;
  logic [6:0] HEX6;
  logic [6:0] HEX7;

  modport master (
    output adjust, select, page_btn,
    output millisecond, second, minute, hour, day, month, year_l, year_h,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7
  );

  modport slave (
    input  adjust, select, page_btn,
    input  millisecond, second, minute, hour, day, month, year_l, year_h,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7
  );
endinterface
`default_nettype wire

// File: rtl/time_display.sv
`default_nettype none
// ============================================================================
// Module      : time_display
// Description : Snapshots the asynchronous BCD time/date bus into CLOCK_50,
//               shows a TIME or DATE page of eight digits on HEX7..HEX0,
//               toggles pages by button or automatic rotation, and in adjust
//               mode forces the page of the edited digit and blinks it.
// Ports       : CLOCK_50  - sole clock, rising edge
//               rst_n     - synchronous active-low reset
//               td        - time_display_if.slave (bus, controls, HEX out)
// Revision    : 1.0 - initial release
// ============================================================================
module time_display #(
  parameter int BLINK_HALF    = 12_500_000,
  parameter int ROTATE_CYCLES = 0
) (
  input  wire logic     CLOCK_50,
  input  wire logic     rst_n,
  time_display_if.slave td
);

  localparam int c_blink_w = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int c_rot_w   = (ROTATE_CYCLES > 1) ? $clog2(ROTATE_CYCLES) : 1;
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_HALF - 1);
  localparam logic [c_rot_w-1:0]   c_rot_last   =
    c_rot_w'((ROTATE_CYCLES > 0) ? ROTATE_CYCLES - 1 : 0);
  localparam bit         c_rot_en    = (ROTATE_CYCLES > 0);
  localparam logic [6:0] c_seg_blank = 7'h7F;
  localparam logic [6:0] c_seg_dash  = 7'h3F;

  typedef enum logic {
    PAGE_TIME = 1'b0,
    PAGE_DATE = 1'b1
  } page_e;

  // Active-low segment decode, bit6..0 = g..a; non-decimal nibbles show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return c_seg_dash;
    endcase
  endfunction

  // Registered state
  logic [63:0]          s1_q, s1_d, s2_q, s2_d, snap_q, snap_d;
  logic [2:0]           btn_sync_q, btn_sync_d;  // [0],[1] sync, [2] previous
  logic [2:0]           adj_sync_q, adj_sync_d;
  logic [3:0]           sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d, sel_s3_q, sel_s3_d;
  page_e                page_q, page_d;
  logic [c_rot_w-1:0]   rot_cnt_q, rot_cnt_d;
  logic [c_blink_w-1:0] blink_cnt_q, blink_cnt_d;
  logic                 blink_on_q, blink_on_d;
  logic [7:0][6:0]      hex_q, hex_d;

  // Combinational helpers
  logic [63:0] w_bus;
  logic        w_run;
  logic        w_btn_edge;
  logic        w_rot_wrap;
  logic        w_blink_clr;
  page_e       w_disp_page;
  logic [31:0] w_page_digits;

  // Each field zero-extended to whole nibbles; digit n sits at bits 4n+3..4n.
  assign w_bus = {td.year_h, td.year_l, 3'b000, td.month, 2'b00, td.day,
                  2'b00, td.hour, 1'b0, td.minute, 1'b0, td.second,
                  td.millisecond};

  assign w_run       = adj_sync_q[1];
  assign w_btn_edge  = btn_sync_q[1] & ~btn_sync_q[2];
  assign w_rot_wrap  = c_rot_en && (rot_cnt_q == c_rot_last);
  // Restart the blink phase so a newly selected digit is lit at once.
  assign w_blink_clr = (sel_s2_q != sel_s3_q) | (adj_sync_q[2] & ~adj_sync_q[1]);
  assign w_disp_page = w_run ? page_q : page_e'(sel_s2_q[3]);
  assign w_page_digits = (w_disp_page == PAGE_DATE) ? snap_q[63:32] : snap_q[31:0];

  always_comb begin
    s1_d        = w_bus;
    s2_d        = s1_q;
    snap_d      = snap_q;
    btn_sync_d  = {btn_sync_q[1:0], td.page_btn};
    adj_sync_d  = {adj_sync_q[1:0], td.adjust};
    sel_s1_d    = td.select;
    sel_s2_d    = sel_s1_q;
    sel_s3_d    = sel_s2_q;
    page_d      = page_q;
    rot_cnt_d   = rot_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    hex_d       = hex_q;

    // Two equal consecutive samples mean the bus was not mid-ripple.
    if (s1_q == s2_q) begin
      snap_d = s2_q;
    end

    if (!w_run) begin
      rot_cnt_d = '0;
    end else if (w_btn_edge || w_rot_wrap) begin
      // A coincident button edge and wrap still give one toggle.
      page_d    = (page_q == PAGE_TIME) ? PAGE_DATE : PAGE_TIME;
      rot_cnt_d = '0;
    end else if (c_rot_en) begin
      rot_cnt_d = rot_cnt_q + 1'b1;
    end

    if (w_blink_clr) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == c_blink_last) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end

    // Next blink state is used so the HEX phase lines up with the clear.
    for (int i = 0; i < 8; i++) begin
      hex_d[i] = seg_decode(w_page_digits[4*i +: 4]);
      if (!w_run && (sel_s2_q[2:0] == 3'(i)) && !blink_on_d) begin
        hex_d[i] = c_seg_blank;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      snap_q      <= '0;
      btn_sync_q  <= '0;
      adj_sync_q  <= 3'b111;
      sel_s1_q    <= '0;
      sel_s2_q    <= '0;
      sel_s3_q    <= '0;
      page_q      <= PAGE_TIME;
      rot_cnt_q   <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      hex_q       <= {8{c_seg_blank}};
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      snap_q      <= snap_d;
      btn_sync_q  <= btn_sync_d;
      adj_sync_q  <= adj_sync_d;
      sel_s1_q    <= sel_s1_d;
      sel_s2_q    <= sel_s2_d;
      sel_s3_q    <= sel_s3_d;
      page_q      <= page_d;
      rot_cnt_q   <= rot_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      hex_q       <= hex_d;
    end
  end

  assign td.HEX0 = hex_q[0];
  assign td.HEX1 = hex_q[1];
  assign td.HEX2 = hex_q[2];
  assign td.HEX3 = hex_q[3];
  assign td.HEX4 = hex_q[4];
  assign td.HEX5 = hex_q[5];
  assign td.HEX6 = hex_q[6];
  assign td.HEX7 = hex_q[7];

endmodule
`default_nettype wire
